// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode constants,
// counter sizing and the legal-range check for the occupancy thresholds.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than the address.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit thresh_ok(input int addr_width, input int af_thresh,
                                   input int ae_thresh);
    int depth;
    depth = 1 << addr_width;
    return (addr_width >= 1) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer-facing bundle of the FIFO: the FIFO owns the slave side,
// the surrounding stage (or a bench) owns the master side.
interface sync_fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  localparam int CNT_W = count_width(ADDR_WIDTH);

  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port and one
// combinational read port, so the head word is visible without a read cycle.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; occupancy is tracked by the pointers, and a
  // reset term here would block mapping onto RAM or LUT-RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, almost-full/empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_flex_if.slave fifo
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int CNT_W = count_width(ADDR_WIDTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

  if (!thresh_ok(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_flex: ADDR_WIDTH/AF_THRESH/AE_THRESH out of legal range");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flex: FWFT must be 0 or 1");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head_data;

  // Status is decoded from the registered count, so each accepted operation
  // shows up on the flags one cycle later.
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);

  // Acceptance uses start-of-cycle full/empty; a flush cancels both sides.
  assign wr_acc = fifo.wr_en && !full  && !fifo.clear;
  assign rd_acc = fifo.rd_en && !empty && !fifo.clear;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (fifo.wr_data),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (head_data)
  );

  // NOTE: every variable gets its hold value first, so no path through the
  // branches below leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (fifo.clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      if (fifo.wr_en && full)  overflow_d  = 1'b1;
      if (fifo.rd_en && empty) underflow_d = 1'b1;

      if (rd_acc) begin
        rd_data_d  = head_data;
        rd_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // FWFT presents the head word straight off the array; it reads as zero
  // while empty so stale or uninitialised storage never leaks out.
  always_comb begin
    if (FWFT == FIFO_MODE_FWFT) begin
      fifo.rd_data  = empty ? '0 : head_data;
      fifo.rd_valid = !empty;
    end else begin
      fifo.rd_data  = rd_data_q;
      fifo.rd_valid = rd_valid_q;
    end
  end

  assign fifo.full         = full;
  assign fifo.empty        = empty;
  assign fifo.almost_full  = (count_q >= AF_C);
  assign fifo.almost_empty = (count_q <= AE_C);
  assign fifo.count        = count_q;
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

  // Structural invariants: occupancy is bounded and always equals the
  // pointer distance, including across wrap-bit crossings.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);
  a_ptr_distance : assert property (@(posedge clk) disable iff (!rst_n)
    CNT_W'(wr_ptr_q - rd_ptr_q) == count_q);

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-mode and an FWFT instance
// driven from vector tables and short hand-written sequences.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_s ();
  sync_fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_f ();

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0),
                   .AF_THRESH(14), .AE_THRESH(2))
    u_std (.clk(clk), .rst_n(rst_n), .fifo(if_s.slave));

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1),
                   .AF_THRESH(14), .AE_THRESH(2))
    u_fwft (.clk(clk), .rst_n(rst_n), .fifo(if_f.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clear;
    logic [4:0] count;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic       chk_data;
    logic [7:0] rd_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Status word: {count, rd_valid, full, empty, af, ae, ovf, unf}
  function automatic logic [11:0] status_s();
    return {if_s.count, if_s.rd_valid, if_s.full, if_s.empty,
            if_s.almost_full, if_s.almost_empty, if_s.overflow, if_s.underflow};
  endfunction

  function automatic logic [11:0] status_f();
    return {if_f.count, if_f.rd_valid, if_f.full, if_f.empty,
            if_f.almost_full, if_f.almost_empty, if_f.overflow, if_f.underflow};
  endfunction

  function automatic vec_t mk(input bit we, input bit [7:0] wd, input bit re,
                              input bit clr, input int cnt, input bit rv,
                              input bit ovf, input bit unf, input bit cd,
                              input bit [7:0] rdd);
    vec_t v;
    v.wr_en = we;  v.wr_data = wd; v.rd_en = re; v.clear = clr;
    v.count = 5'(cnt);
    v.rd_valid = rv;
    v.full  = (cnt == 16);
    v.empty = (cnt == 0);
    v.af    = (cnt >= 14);
    v.ae    = (cnt <= 2);
    v.ovf = ovf; v.unf = unf; v.chk_data = cd; v.rd_data = rdd;
    return v;
  endfunction

  task automatic idle_inputs();
    if_s.clear = 0; if_s.wr_en = 0; if_s.wr_data = '0; if_s.rd_en = 0;
    if_f.clear = 0; if_f.wr_en = 0; if_f.wr_data = '0; if_f.rd_en = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input bit we, input bit [7:0] wd, input bit re,
                         input bit clr);
    if_s.wr_en = we; if_s.wr_data = wd; if_s.rd_en = re; if_s.clear = clr;
    step();
  endtask

  task automatic drive_f(input bit we, input bit [7:0] wd, input bit re);
    if_f.wr_en = we; if_f.wr_data = wd; if_f.rd_en = re; if_f.clear = 0;
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Tests 1/2: fill to full, overflow attempt, drain, underflow, clear.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 8'(i), 0, 0, i + 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'hAA, 0, 0, 16, 0, 1, 0, 0, 8'h00));
    for (int j = 0; j < 16; j++)
      vecs.push_back(mk(0, 8'h00, 1, 0, 15 - j, 1, 1, 0, 1, 8'(j)));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 8'h0F));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 8'h0F));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h0F));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset_std_status", 32'(status_s()), 32'b00000_0_0_1_0_1_0_0);
    check("reset_std_rd_data", 32'(if_s.rd_data), 32'h00);
    check("reset_fwft_status", 32'(status_f()), 32'b00000_0_0_1_0_1_0_0);

    foreach (vecs[i]) begin
      drive_s(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en, vecs[i].clear);
      check($sformatf("t12_vec%0d_status", i), 32'(status_s()),
            32'({vecs[i].count, vecs[i].rd_valid, vecs[i].full, vecs[i].empty,
                 vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].unf}));
      if (vecs[i].chk_data)
        check($sformatf("t12_vec%0d_rd_data", i), 32'(if_s.rd_data),
              32'(vecs[i].rd_data));
    end

    // Test 3: count held at 5 under 40 cycles of simultaneous push/pop.
    for (int i = 0; i < 5; i++) drive_s(1, 8'(8'h10 + i), 0, 0);
    check("t3_prefill_count", 32'(if_s.count), 32'd5);
    for (int i = 0; i < 40; i++) begin
      drive_s(1, 8'(8'h20 + i), 1, 0);
      check($sformatf("t3_cyc%0d_status", i), 32'(status_s()),
            32'b00101_1_0_0_0_0_0_0);
      check($sformatf("t3_cyc%0d_rd_data", i), 32'(if_s.rd_data),
            (i < 5) ? 32'(8'h10 + i) : 32'(8'h20 + i - 5));
    end
    for (int i = 0; i < 5; i++) begin
      drive_s(0, 8'h00, 1, 0);
      check($sformatf("t3_drain%0d_rd_data", i), 32'(if_s.rd_data),
            32'(8'h43 + i));
    end
    check("t3_end_status", 32'(status_s()), 32'b00000_1_0_1_0_1_0_0);

    // Test 5: simultaneous read+write on empty, then clear beats a write.
    drive_s(1, 8'h55, 1, 0);
    check("t5_rw_empty_status", 32'(status_s()), 32'b00001_0_0_0_0_1_0_1);
    drive_s(1, 8'h66, 0, 1);
    check("t5_clear_status", 32'(status_s()), 32'b00000_0_0_1_0_1_0_0);
    drive_s(0, 8'h00, 0, 0);
    check("t5_after_clear_status", 32'(status_s()), 32'b00000_0_0_1_0_1_0_0);

    // Test 4: FWFT head word visible without rd_en.
    drive_f(1, 8'h3C, 0);
    check("t4_wr_status", 32'(status_f()), 32'b00001_1_0_0_0_1_0_0);
    check("t4_wr_rd_data", 32'(if_f.rd_data), 32'h3C);
    drive_f(0, 8'h00, 0);
    check("t4_hold_rd_data", 32'(if_f.rd_data), 32'h3C);
    drive_f(0, 8'h00, 1);
    check("t4_pop_status", 32'(status_f()), 32'b00000_0_0_1_0_1_0_0);
    drive_f(1, 8'h11, 0);
    drive_f(1, 8'h22, 0);
    check("t4_two_head", 32'(if_f.rd_data), 32'h11);
    check("t4_two_count", 32'(if_f.count), 32'd2);
    drive_f(0, 8'h00, 1);
    check("t4_second_head", 32'(if_f.rd_data), 32'h22);
    drive_f(0, 8'h00, 1);
    check("t4_drained_status", 32'(status_f()), 32'b00000_0_0_1_0_1_0_0);
    idle_inputs();

    // Test 6: asynchronous reset mid-cycle with 9 words and a read in flight.
    for (int i = 0; i < 9; i++) drive_s(1, 8'(8'h30 + i), 0, 0);
    drive_s(0, 8'h00, 1, 0);
    check("t6_pre_rd_data", 32'(if_s.rd_data), 32'h30);
    check("t6_pre_count", 32'(if_s.count), 32'd8);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_status", 32'(status_s()), 32'b00000_0_0_1_0_1_0_0);
    check("t6_async_rd_data", 32'(if_s.rd_data), 32'h00);
    #2;
    idle_inputs();
    rst_n = 1'b1;
    step();
    drive_s(1, 8'h77, 0, 0);
    check("t6_post_wr_count", 32'(if_s.count), 32'd1);
    drive_s(0, 8'h00, 1, 0);
    check("t6_post_rd_data", 32'(if_s.rd_data), 32'h77);
    check("t6_post_rd_status", 32'(status_s()), 32'b00000_1_0_1_0_1_0_0);
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock, parametrised FIFO. It is the same-domain successor of our dual-clock FIFO, for paths where producer and consumer share clk. It adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- occupancy count
- programmable almost-full and almost-empty thresholds
- synchronous flush
- sticky overflow and underflow error flags

It sits between a producer and a consumer stage in the datapath as a rate-smoothing buffer.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries, ADDR_WIDTH >= 1.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of pointers, count and error flags.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write word.
- rd_en  input  1  read request (FWFT: pop/acknowledge of the head word).
- rd_data  output  DATA_WIDTH  read word.
- rd_valid  output  1  standard mode: rd_data updated this cycle; FWFT: equals !empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:

Reset (rst_n low, asynchronous):
- wr_ptr, rd_ptr and count = 0.
- rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
- Resulting outputs: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0 ? 1 : 0), i.e. 0 for the legal range.
- Memory contents are not reset.
- Reset mid-operation discards all stored data. The first write after rst_n rises is accepted normally.

Pointers:
- wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
- Both wrap modulo 2*DEPTH naturally.

Write/read acceptance:
- wr_acc = wr_en && !full; rd_acc = rd_en && !empty.
- Both use the full/empty value present at the start of the cycle. A write is rejected when full even if a read is accepted in the same cycle. A read is rejected when empty even if a write is accepted in the same cycle.

count (registered):
- count_next = count + wr_acc - rd_acc.
- Simultaneous wr_acc and rd_acc leaves count unchanged.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count. Each reflects an accepted operation one cycle after it.

Standard mode (FWFT = 0):
- On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the next edge.
- Otherwise rd_valid <= 0 and rd_data holds its value.
- Read latency is 1 cycle.

FWFT mode (FWFT = 1):
- rd_data always presents mem[rd_ptr] (head word) whenever empty = 0.
- rd_valid = !empty.
- rd_acc advances to the next word, visible the cycle after the edge.
- Write-to-visible latency is 1 cycle (written at edge N, empty falls after edge N).

Error flags:
- overflow is set on (wr_en && full); underflow is set on (rd_en && empty).
- Both hold until clear or reset.
- Rejected operations do not change pointers, count or memory.

clear:
- Has priority over wr_en and rd_en in the same cycle; the write is dropped and the read is dropped.
- Pointers, count, overflow, underflow and rd_valid go to 0.
- rd_data holds in standard mode.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1 constants
  - a function computing the count width from ADDR_WIDTH
  - a threshold-range check used by elaboration assertions
- One sub-module, fifo_ram: 2**ADDR_WIDTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port. The top module instantiates it and owns all pointer, count, flag and read-register logic.

Test Plan:
1. Reset, then 16 writes of 0x00..0x0F (defaults, standard mode) -> count steps to 16, almost_full rises when count = 14, full = 1 after the 16th, overflow stays 0.
2. From full, a 17th write of 0xAA -> write ignored, overflow = 1 sticky, count = 16. Then 16 reads -> rd_data sequence 0x00..0x0F, each with rd_valid 1 cycle after rd_en, empty = 1 at the end.
3. With count = 5, hold wr_en and rd_en together for 40 cycles with incrementing data -> count stays 5, pointers wrap at least twice, data order preserved, no error flags.
4. FWFT = 1: write 0x3C into empty FIFO -> next cycle empty = 0, rd_valid = 1, rd_data = 0x3C with no rd_en. Pulse rd_en -> empty = 1 the next cycle.
5. On an empty FIFO, assert rd_en and wr_en(0x55) together -> read rejected, underflow = 1, count = 1. Then clear with wr_en = 1 -> count = 0, underflow = 0, overflow = 0, write dropped.
6. With count = 9 and a read in flight, drop rst_n asynchronously mid-cycle -> all outputs go to their reset values immediately. Then write 0x77 and read -> rd_data = 0x77.
